mux_sel_arbiter: RTL and testbench
==================================

Name: mux_sel_arbiter

Overview:
Two-requester round-robin arbiter that drives the select line `s` of the 2:1 gate-level mux. Sources A and B request the shared output path. The arbiter grants one source at a time, enforces a minimum and a maximum hold time, and sets `sel` so the downstream mux passes the granted source (`sel=0` passes `a`, `sel=1` passes `b`). All outputs are registered, so the mux select never glitches.

Parameters:
- MIN_HOLD, 2: minimum number of cycles a grant is held, even if the owner drops its request.
- MAX_HOLD, 8: number of cycles after which the owner is preempted, if the other source is requesting.
- CNT_W, 4: width of the hold counter. Legal configuration: 1 <= MIN_HOLD <= MAX_HOLD <= 2^CNT_W - 1.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_a  in  1  source A requests the path (level, sampled every clk).
- req_b  in  1  source B requests the path.
- gnt_a  out  1  A owns the path.
- gnt_b  out  1  B owns the path.
- sel  out  1  select to the 2:1 mux: 0 selects A, 1 selects B.
- busy  out  1  high when gnt_a or gnt_b is high.

Behaviour:
- One clock; reset is asynchronous and active-low.
  - Assertion clears state immediately, with no clock edge needed.
  - Deassertion takes effect at the next clk edge.
- Reset values:
  - state = IDLE; gnt_a = 0, gnt_b = 0, busy = 0, sel = 0.
  - hold counter cnt = 0.
  - last-owner flag = B, so A wins the first tie.
- States: IDLE, OWN_A, OWN_B. All outputs are decoded from registered state; no combinational path from req to gnt.
- IDLE:
  - req_a & req_b: grant the source that is not "last".
  - Single request: grant that source.
  - Otherwise stay in IDLE.
  - Latency: req sampled at edge N gives gnt high after edge N.
- On entry to OWN_X:
  - cnt = 1, last = X.
  - sel = 0 for A, 1 for B.
- In OWN_X, evaluated at each edge with the current cnt:
  - Release if (!req_X && cnt >= MIN_HOLD) or (req_other && cnt >= MAX_HOLD).
  - On release with req_other high: go directly to OWN_other. No idle gap; gnt_X falls and gnt_other rises on the same edge; sel toggles on that same edge.
  - On release with req_other low: go to IDLE.
  - No release: stay in OWN_X; cnt increments, saturating at MAX_HOLD.
- Boundary cases:
  - Owner drops req before MIN_HOLD: grant is still held until cnt reaches MIN_HOLD.
  - Owner requests beyond MAX_HOLD with no competitor: stays granted indefinitely, cnt saturates.
  - Competitor appears after saturation: preemption happens at the very next edge.
- sel holds its last value in IDLE. It never changes except on a transition into OWN_A or OWN_B.
- Invariants:
  - gnt_a & gnt_b is never 1.
  - busy == gnt_a | gnt_b.
  - In OWN_X, sel always matches the owner.
- Reset mid-grant:
  - All grants drop asynchronously and last returns to B.
  - The first grant after reset follows the IDLE rules (A wins a tie).

Test Plan:
1. Hold rst_n=0 with random req toggling, no clk edges required → gnt_a=0, gnt_b=0, busy=0, sel=0 throughout.
2. req_a=1 for exactly one cycle (sampled at edge 0), req_b=0 → gnt_a=1 after edges 0 and 1 (two cycles), IDLE after edge 2; sel stays 0.
3. req_a=req_b=1 held continuously from reset release → gnt_a for 8 cycles, then gnt_b for 8 cycles, alternating. sel toggles 0→1→0 on the switch edges, busy never drops, grants never overlap.
4. req_b alone granted at edge 0, req_a rises at cycle 12 → gnt_b is already saturated (cnt=8), so switch at edge 12: gnt_b=0, gnt_a=1, sel=0.
5. Both requesting; A granted; req_a drops when cnt=4 → gnt_b=1 on the next edge with no idle cycle; sel=1.
6. rst_n pulsed low mid-OWN_B (cnt=5) with both requests held → outputs clear asynchronously. After release, the first grant is to A (tie broken by reset last=B), one cycle after the first sampling edge.

Source files
------------

// File: rtl/mux_sel_arbiter.sv
// Two-requester round-robin arbiter driving the select of a 2:1 mux.
// Grants are held between MIN_HOLD and MAX_HOLD cycles; all outputs are registered.
module mux_sel_arbiter #(
    parameter int unsigned MIN_HOLD = 2,
    parameter int unsigned MAX_HOLD = 8,
    parameter int unsigned CNT_W    = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_a,
    input  logic req_b,
    output logic gnt_a,
    output logic gnt_b,
    output logic sel,
    output logic busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_HOLD);
    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             last_b;

    logic             rel_a_c;
    logic             rel_b_c;
    logic             pick_a_c;
    logic             pick_b_c;
    logic [CNT_W-1:0] cnt_inc_c;

    // Release conditions for the current owner, evaluated against the current hold count.
    assign rel_a_c   = (!req_a && (cnt >= MIN_C)) || (req_b && (cnt >= MAX_C));
    assign rel_b_c   = (!req_b && (cnt >= MIN_C)) || (req_a && (cnt >= MAX_C));
    // From idle, A wins unless B also requests and A was the last owner.
    assign pick_a_c  = req_a && (!req_b || last_b);
    assign pick_b_c  = req_b && !pick_a_c;
    assign cnt_inc_c = (cnt >= MAX_C) ? MAX_C : cnt + ONE_C;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            last_b <= 1'b1;
            gnt_a  <= 1'b0;
            gnt_b  <= 1'b0;
            sel    <= 1'b0;
            busy   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_a_c) begin
                        state  <= OWN_A;
                        cnt    <= ONE_C;
                        last_b <= 1'b0;
                        gnt_a  <= 1'b1;
                        gnt_b  <= 1'b0;
                        sel    <= 1'b0;
                        busy   <= 1'b1;
                    end else if (pick_b_c) begin
                        state  <= OWN_B;
                        cnt    <= ONE_C;
                        last_b <= 1'b1;
                        gnt_a  <= 1'b0;
                        gnt_b  <= 1'b1;
                        sel    <= 1'b1;
                        busy   <= 1'b1;
                    end
                end
                OWN_A: begin
                    if (rel_a_c && req_b) begin
                        state  <= OWN_B;
                        cnt    <= ONE_C;
                        last_b <= 1'b1;
                        gnt_a  <= 1'b0;
                        gnt_b  <= 1'b1;
                        sel    <= 1'b1;
                        busy   <= 1'b1;
                    end else if (rel_a_c) begin
                        state <= IDLE;
                        cnt   <= '0;
                        gnt_a <= 1'b0;
                        gnt_b <= 1'b0;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt_inc_c;
                    end
                end
                OWN_B: begin
                    if (rel_b_c && req_a) begin
                        state  <= OWN_A;
                        cnt    <= ONE_C;
                        last_b <= 1'b0;
                        gnt_a  <= 1'b1;
                        gnt_b  <= 1'b0;
                        sel    <= 1'b0;
                        busy   <= 1'b1;
                    end else if (rel_b_c) begin
                        state <= IDLE;
                        cnt   <= '0;
                        gnt_a <= 1'b0;
                        gnt_b <= 1'b0;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt_inc_c;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    gnt_a <= 1'b0;
                    gnt_b <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Directed bench for mux_sel_arbiter with hand-computed expected grants.
module tb_mux_sel_arbiter;

    logic clk;
    logic rst_n;
    logic req_a;
    logic req_b;
    logic gnt_a;
    logic gnt_b;
    logic sel;
    logic busy;

    int passed;
    int total;

    mux_sel_arbiter #(
        .MIN_HOLD(2),
        .MAX_HOLD(8),
        .CNT_W   (4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .req_a(req_a),
        .req_b(req_b),
        .gnt_a(gnt_a),
        .gnt_b(gnt_b),
        .sel  (sel),
        .busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    task automatic expect_out(input string tag, input logic ea, input logic eb, input logic es);
        chk($sformatf("%s gnt_a", tag), gnt_a, ea);
        chk($sformatf("%s gnt_b", tag), gnt_b, eb);
        chk($sformatf("%s sel", tag), sel, es);
        chk($sformatf("%s busy", tag), busy, ea | eb);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse reset low away from the clock edge; release so the next posedge is edge 0.
    task automatic do_reset(input string tag);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        expect_out(tag, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        rst_n  = 1'b1;
        req_a  = 1'b0;
        req_b  = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        expect_out("t1 async", 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            req_a = 1'($urandom_range(0, 1));
            req_b = 1'($urandom_range(0, 1));
            #7;
            expect_out($sformatf("t1 hold%0d", i), 1'b0, 1'b0, 1'b0);
        end

        // Single one-cycle request from A: held for MIN_HOLD, then idle.
        req_a = 1'b0;
        req_b = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        req_a = 1'b1;
        tick();
        expect_out("t2 e0", 1'b1, 1'b0, 1'b0);
        req_a = 1'b0;
        tick();
        expect_out("t2 e1", 1'b1, 1'b0, 1'b0);
        tick();
        expect_out("t2 e2", 1'b0, 1'b0, 1'b0);
        tick();
        expect_out("t2 e3", 1'b0, 1'b0, 1'b0);

        // Both requesting continuously: 8-cycle alternation starting with A.
        req_a = 1'b1;
        req_b = 1'b1;
        do_reset("t3 rst");
        for (int k = 0; k < 32; k++) begin
            tick();
            if (((k / 8) % 2) == 0)
                expect_out($sformatf("t3 e%0d", k), 1'b1, 1'b0, 1'b0);
            else
                expect_out($sformatf("t3 e%0d", k), 1'b0, 1'b1, 1'b1);
        end

        // B alone saturates; A arriving later preempts at the very next edge.
        req_a = 1'b0;
        req_b = 1'b1;
        do_reset("t4 rst");
        for (int k = 0; k < 12; k++) begin
            tick();
            expect_out($sformatf("t4 e%0d", k), 1'b0, 1'b1, 1'b1);
        end
        req_a = 1'b1;
        tick();
        expect_out("t4 e12", 1'b1, 1'b0, 1'b0);

        // A owns with both requesting; A drops at cnt=4 and B takes over with no gap.
        for (int k = 13; k < 16; k++) begin
            tick();
            expect_out($sformatf("t5 e%0d", k), 1'b1, 1'b0, 1'b0);
        end
        req_a = 1'b0;
        tick();
        expect_out("t5 e16", 1'b0, 1'b1, 1'b1);

        // Reset during OWN_B at cnt=5 with both requesting; A wins after release.
        req_a = 1'b1;
        for (int k = 17; k < 21; k++) begin
            tick();
            expect_out($sformatf("t6 e%0d", k), 1'b0, 1'b1, 1'b1);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        expect_out("t6 async", 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        expect_out("t6 e0", 1'b1, 1'b0, 1'b0);
        tick();
        expect_out("t6 e1", 1'b1, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
